dual_port_memory: RTL
=====================

Name: dual_port_memory

Overview:
- Parametrised successor to the single-port, combinational-read instruction/data memory.
- One shared storage array serves two ports: a read-only instruction port (I) and a read/write data port (D).
- Each port has a registered, fixed-latency request/valid handshake. D-port writes use byte enables.
- Sits between the core's fetch and load/store stages and the storage array; the testbench preloads contents hierarchically into the array named mem.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 7, word-address width on both ports
DEPTH, 128, implemented words; must be <= 2**ADDR_WIDTH
LATENCY, 1, cycles from accept to valid; must be >= 1

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
i_req  in  1  instruction read request
i_addr  in  ADDR_WIDTH  instruction word address
i_ready  out  1  I port can accept a request this cycle
i_valid  out  1  I response valid, one-cycle pulse
i_rdata  out  DATA_WIDTH  instruction word
i_err  out  1  I address was out of range; qualified by i_valid
d_req  in  1  data request
d_we  in  1  1 = write, 0 = read
d_be  in  DATA_WIDTH/8  byte enables for writes; bit n covers byte n
d_addr  in  ADDR_WIDTH  data word address
d_wdata  in  DATA_WIDTH  write data
d_ready  out  1  D port can accept a request this cycle
d_valid  out  1  D response valid (reads and writes), one-cycle pulse
d_rdata  out  DATA_WIDTH  read data; 0 for writes
d_err  out  1  D address was out of range; qualified by d_valid

Behaviour:
- Reset: synchronous on rising clk while rst_n = 0.
  - Clears both port counters.
  - Outputs after reset: i_valid/d_valid/i_err/d_err = 0, i_rdata/d_rdata = 0, i_ready/d_ready = 1.
  - mem contents are never reset.
- Port controller, one per port, built around a down-counter cnt:
  - IDLE: cnt = 0.
  - BUSY: cnt > 1.
  - RESP: cnt = 1.
  - ready = (cnt <= 1).
  - Accept = req && ready at a rising edge; accept loads cnt = LATENCY.
  - No accept: cnt decrements while > 0.
  - valid = (cnt == 1). Valid therefore rises exactly LATENCY cycles after the accept edge.
  - Accept while in RESP is allowed, so back-to-back throughput is one request per LATENCY cycles (one per cycle at LATENCY = 1).
  - req while not ready is ignored; there is no queuing. The requester must hold req until ready.
- Memory access occurs at the accept edge:
  - Read data is captured into the port's rdata register at accept and held, stable, until the next accept or reset.
  - Writes update mem at accept: only bytes with d_be[n] = 1 are written. d_be = 0 on a write is a legal no-op that still produces d_valid.
- Out-of-range address (addr >= DEPTH):
  - Read returns 0 and sets err with valid.
  - Write is suppressed and sets d_err.
- Same-edge D write and I read to the same address: I returns the old data (read-before-write). A subsequent I read returns the new data.
- D read accepted on the edge right after a D write to the same address returns the written data.
- Reset mid-operation: pending responses are dropped and no valid is issued. A write accepted before reset remains in mem.
- Widths: the address is used directly as the word index, with no byte-offset bits. err is 0 whenever valid is 0.

Decomposition:
- Package mem_pkg:
  - BYTE_W = 8.
  - Function for byte-enable width (DATA_WIDTH/8).
  - Function for the byte-merge mask.
  - Default parameter constants.
- Sub-module mem_port_ctrl: cnt/ready/valid handshake, parametrised by LATENCY, instantiated once per port.
- The array and byte-merge write logic stay in the top.

Test Plan:
1. Reset, LATENCY = 1, mem[5] = 32'hDEADBEEF preloaded; I read addr 5 -> i_valid high for one cycle on the next cycle, i_rdata = 32'hDEADBEEF, i_err = 0.
2. D write addr 10, wdata 32'h11223344, be 4'b0101, over mem[10] = 32'hAABBCCDD -> d_valid after 1 cycle. A following D read of addr 10 returns 32'hAA22CC44.
3. LATENCY = 3; I req at cycle 0, held high -> i_ready low in cycles 1–2, i_valid only in cycle 3, second accept in cycle 3, second valid in cycle 6.
4. Same edge: D write 32'h0 to addr 7 and I read of addr 7 (old value 32'h12345678) -> i_rdata = 32'h12345678. Next I read of addr 7 -> 32'h0.
5. DEPTH = 100; D write 32'hFFFFFFFF to addr 120, then D read of addr 120 -> d_err = 1 with both d_valid pulses, d_rdata = 0, mem unchanged.
6. LATENCY = 3; assert rst_n = 0 one cycle after accepting a D read -> no d_valid, d_rdata = 0, d_ready = 1 the cycle after reset is released.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and helpers for the dual-port memory.
package mem_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned MAX_DATA_W     = 256;
    localparam int unsigned MAX_BE_W       = MAX_DATA_W / BYTE_W;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 7;
    localparam int unsigned DEF_DEPTH      = 128;
    localparam int unsigned DEF_LATENCY    = 1;

    // Handshake phase of a port controller, derived from its down-counter.
    typedef enum logic [1:0] {
        PORT_IDLE = 2'd0,
        PORT_BUSY = 2'd1,
        PORT_RESP = 2'd2
    } port_state_e;

    // Number of byte lanes in a data word.
    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / BYTE_W;
    endfunction

    // Expand byte enables into a bit mask; callers truncate to their word width.
    function automatic logic [MAX_DATA_W-1:0] byte_mask(input logic [MAX_BE_W-1:0] be);
        logic [MAX_DATA_W-1:0] mask;
        mask = '0;
        for (int unsigned n = 0; n < MAX_BE_W; n++) begin
            mask[n*BYTE_W +: BYTE_W] = {BYTE_W{be[n]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dual_port_memory_if.sv
// Instruction (read-only) and data (read/write) port bundle.
interface dual_port_memory_if
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
    localparam int unsigned BE_W = be_width(DATA_WIDTH);

    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ready;
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_err;

    logic                  d_req;
    logic                  d_we;
    logic [BE_W-1:0]       d_be;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ready;
    logic                  d_valid;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_err;

    modport master (
        output i_req, i_addr,
        input  i_ready, i_valid, i_rdata, i_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_ready, d_valid, d_rdata, d_err
    );

    modport slave (
        input  i_req, i_addr,
        output i_ready, i_valid, i_rdata, i_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_ready, d_valid, d_rdata, d_err
    );

endinterface

// File: rtl/mem_port_ctrl.sv
// Fixed-latency request/valid handshake for one memory port.
module mem_port_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic range_err,
    output logic accept_c,
    output logic ready,
    output logic valid,
    output logic err
);
    localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             err_pend;
    logic             err_next;
    port_state_e      state_next;

    // No accepts while reset is asserted so memory is never touched during reset.
    assign accept_c = rst_n && req && ready;

    // Next counter value, phase and error flag for the pending response.
    always_comb begin
        cnt_next   = cnt;
        err_next   = err_pend;
        state_next = PORT_IDLE;
        if (accept_c) begin
            cnt_next = CNT_W'(LATENCY);
            err_next = range_err;
        end else if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
        end
        if (cnt_next == CNT_W'(1)) begin
            state_next = PORT_RESP;
        end else if (cnt_next != '0) begin
            state_next = PORT_BUSY;
        end
    end

    // Counter plus registered ready/valid/err decoded from the next phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            err_pend <= 1'b0;
            ready    <= 1'b1;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            err_pend <= err_next;
            ready    <= (state_next != PORT_BUSY);
            valid    <= (state_next == PORT_RESP);
            err      <= (state_next == PORT_RESP) && err_next;
        end
    end

endmodule

// File: rtl/dual_port_memory.sv
// Shared word array with a read-only instruction port and a byte-enabled data port.
module dual_port_memory
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned LATENCY    = DEF_LATENCY
) (
    input logic                clk,
    input logic                rst_n,
    dual_port_memory_if.slave  bus
);
    localparam int unsigned BE_W  = be_width(DATA_WIDTH);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH > MAX_DATA_W || BE_W > MAX_BE_W) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8 and at most 256");
    end
    if (DEPTH > (1 << ADDR_WIDTH) || DEPTH == 0) begin : g_bad_depth
        $error("DEPTH must be between 1 and 2**ADDR_WIDTH");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("LATENCY must be at least 1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  i_accept;
    logic                  d_accept;
    logic                  i_in_range;
    logic                  d_in_range;
    logic [IDX_W-1:0]      i_idx;
    logic [IDX_W-1:0]      d_idx;
    logic [DATA_WIDTH-1:0] wmask;

    assign i_in_range = 32'(bus.i_addr) < DEPTH;
    assign d_in_range = 32'(bus.d_addr) < DEPTH;
    assign i_idx      = IDX_W'(bus.i_addr);
    assign d_idx      = IDX_W'(bus.d_addr);
    assign wmask      = DATA_WIDTH'(byte_mask(MAX_BE_W'(bus.d_be)));

    mem_port_ctrl #(.LATENCY(LATENCY)) u_i_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.i_req),
        .range_err (!i_in_range),
        .accept_c  (i_accept),
        .ready     (bus.i_ready),
        .valid     (bus.i_valid),
        .err       (bus.i_err)
    );

    mem_port_ctrl #(.LATENCY(LATENCY)) u_d_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.d_req),
        .range_err (!d_in_range),
        .accept_c  (d_accept),
        .ready     (bus.d_ready),
        .valid     (bus.d_valid),
        .err       (bus.d_err)
    );

    // Byte-merged write at accept; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (d_accept && bus.d_we && d_in_range) begin
            mem[d_idx] <= (mem[d_idx] & ~wmask) | (bus.d_wdata & wmask);
        end
    end

    // Read data captured at accept and held; same-edge writes are not yet visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
        end else begin
            if (i_accept) begin
                bus.i_rdata <= i_in_range ? mem[i_idx] : '0;
            end
            if (d_accept) begin
                bus.d_rdata <= (d_in_range && !bus.d_we) ? mem[d_idx] : '0;
            end
        end
    end

endmodule
